// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall patterns, FSM states,
// exception codes. Optional watchdog is enabled by macro PIPE_CTRL_WDOG_EN.
package pipe_ctrl_pkg;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [5:0]  STALL_ALL  = 6'b111111;

  localparam logic        STOP       = 1'b1;
  localparam logic        NOSTOP     = 1'b0;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [31:0] EXC_NONE   = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled RUN cycles and flags the cycle
// on which the limit is reached while the pipeline is still stalled.
module pipe_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled_i,
  input  logic clear_i,
  output logic fire_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !stalled_i) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire_o = stalled_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences exception/eret entry
// with a one-cycle flush. Watchdog present only when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE   = EXC_ERET,
  parameter int unsigned WDOG_LIMIT  = 1024,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_timeout
);

  state_e      state_q;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic [5:0]  req_stall_s;
  logic        exc_acc_s;
  logic        wdog_acc_s;
  logic        accept_s;
  logic [31:0] target_s;

  always_comb begin
    req_stall_s = STALL_NONE;
    if (stallreq_from_mem == STOP) begin
      req_stall_s = STALL_MEM;
    end else if (stallreq_from_ex == STOP) begin
      req_stall_s = STALL_EX;
    end else if (stallreq_from_id == STOP) begin
      req_stall_s = STALL_ID;
    end else begin
      req_stall_s = STALL_NONE;
    end
  end

  // An exception waits while mem is mid-access; mem keeps excepttype_i stable.
  assign exc_acc_s = (state_q == ST_RUN) && (excepttype_i != EXC_NONE) &&
                     (stallreq_from_mem == NOSTOP);
  assign accept_s  = exc_acc_s || wdog_acc_s;

  always_comb begin
    target_s = WDOG_VECTOR;
    if (exc_acc_s) begin
      target_s = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end else begin
      target_s = WDOG_VECTOR;
    end
  end

  always_comb begin
    stall = STALL_NONE;
    if (rst) begin
      stall = STALL_NONE;
    end else if (state_q == ST_FLUSH) begin
      stall = STALL_NONE;
    end else if (accept_s) begin
      stall = STALL_ALL;
    end else begin
      stall = req_stall_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= ZeroWord;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept_s) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= target_s;
          end else begin
            flush_q  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_WDOG_EN
  logic wdog_fire_s;
  logic wdog_timeout_q;

  pipe_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .stalled_i ((state_q == ST_RUN) && (req_stall_s != STALL_NONE)),
    .clear_i   (exc_acc_s),
    .fire_o    (wdog_fire_s)
  );

  // A real exception in the same cycle wins over the watchdog.
  assign wdog_acc_s = wdog_fire_s && !exc_acc_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_timeout_q <= 1'b0;
    end else if (wdog_acc_s) begin
      wdog_timeout_q <= 1'b1;
    end else begin
      wdog_timeout_q <= wdog_timeout_q;
    end
  end

  assign wdog_timeout = wdog_timeout_q;
`else
  logic [31:0] unused_wdog_s;
  assign unused_wdog_s = WDOG_VECTOR ^ 32'(WDOG_LIMIT);
  assign wdog_acc_s    = 1'b0;
  assign wdog_timeout  = 1'b0;
`endif

endmodule
